iteration_counter: RTL

- Parameterised iteration/step counter for the square-root datapath sequencers.
- Generalises the fixed-modulus down-counter: runtime-programmable limit, up or down direction, wrap or one-shot mode.
- Adds a near-end lookahead flag, one-cycle done/wrap pulses and synchronous abort.
- Sits beside each iterative datapath FSM and tells it when the last iteration is reached.

---
 rtl/iteration_counter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/iteration_counter.sv
// Programmable up/down iteration counter with wrap or one-shot termination.
// Tells an iterative datapath FSM when its last step is reached, with a near-end lookahead.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no run in progress; count forced to 0, all flags low
// RUN   | counting on enable; terminal step wraps or finishes
// DONE  | one-shot run finished; count held at terminal, busy low
module iteration_counter #(
    parameter int NBITS     = 5,
    parameter int NEAR_DIST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             enable,
    input  logic [NBITS-1:0] limit,
    input  logic             up_down,
    input  logic             one_shot,
    output logic [NBITS-1:0] count,
    output logic             busy,
    output logic             at_start,
    output logic             at_end,
    output logic             near_end,
    output logic             wrap,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NBITS-1:0] NEAR_V = NBITS'(NEAR_DIST);
    localparam logic [NBITS-1:0] ONE    = NBITS'(1);
    localparam logic [NBITS-1:0] ZERO   = '0;

    state_t           state_q, state_d;
    logic [NBITS-1:0] count_q, count_d;
    logic [NBITS-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic [NBITS-1:0] start_val;
    logic [NBITS-1:0] term_val;

    // dir_q = 1 counts up from 0 to limit_q; 0 counts down from limit_q to 0
    assign start_val = dir_q ? ZERO : limit_q;
    assign term_val  = dir_q ? limit_q : ZERO;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            // the new configuration takes effect immediately, so the start
            // value comes from the inputs rather than the config registers
            limit_d = limit;
            dir_d   = up_down;
            mode_d  = one_shot;
            count_d = up_down ? ZERO : limit;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (enable) begin
                        if (count_q == term_val) begin
                            if (mode_q) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                count_d = start_val;
                                wrap_d  = 1'b1;
                            end
                        end else if (dir_q) begin
                            count_d = count_q + ONE;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                DONE: begin
                    count_d = count_q;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == RUN);
        at_start = (state_q != IDLE) && (count_q == start_val);
        at_end   = (state_q != IDLE) && (count_q == term_val);
        near_end = 1'b0;
        if (state_q == RUN) begin
            if (dir_q) begin
                near_end = (limit_q >= NEAR_V) && (count_q == (limit_q - NEAR_V));
            end else begin
                near_end = (count_q == NEAR_V);
            end
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign done  = done_q;

endmodule
